// File: rtl/sparhix_sched_pkg.sv
// Shared scheduler definitions: FSM state encoding and the phase-control bit ordering
// used by fsel_tile_sequencer.
package sparhix_sched_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_ARM   = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_LOAD  = ST_LOAD,
        S_ARM   = ST_ARM,
        S_RUN   = ST_RUN,
        S_DONE  = ST_DONE
    } sched_state_t;

    // Bit positions inside the one-hot phase-control vector.
    localparam int PH_LOAD  = 0;
    localparam int PH_READY = 1;
    localparam int PH_START = 2;
    localparam int PH_W     = 3;

    function automatic logic [PH_W-1:0] phase_of(input sched_state_t s);
        logic [PH_W-1:0] ph;
        ph = '0;
        case (s)
            S_LOAD:  ph[PH_LOAD]  = 1'b1;
            S_ARM:   ph[PH_READY] = 1'b1;
            S_RUN:   ph[PH_START] = 1'b1;
            default: ph = '0;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/sched_phase_counter.sv
// Loadable down-counter shared by the LOAD and RUN phases; expire flags the final
// cycle of a phase (count at 1, or 0 as a safe floor).
module sched_phase_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 f_sel_rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 en,
    output logic                 expire
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk_i or posedge f_sel_rst) begin
        if (f_sel_rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

    assign expire = (count <= CNT_WIDTH'(1));

endmodule

// File: rtl/fsel_tile_sequencer.sv
// Tile sequencer: per tile, fetch a config word then walk the array controller through
// reset -> load -> ready -> start_op. Optional perf counters under `ifdef FSEL_SEQ_PERF_EN.
module fsel_tile_sequencer
    import sparhix_sched_pkg::*;
#(
    parameter int N             = 3,
    parameter int SEL_WIDTH     = $clog2(N),
    parameter int NUM_COL_WIDTH = $clog2(N + 1),
    parameter int LOAD_CYCLES   = N,
    parameter int CNT_WIDTH     = 16,
    parameter int TILE_WIDTH    = 8
) (
    input  logic                     clk_i,
    input  logic                     f_sel_rst,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [TILE_WIDTH-1:0]    num_tiles_i,
    input  logic [CNT_WIDTH-1:0]     op_cycles_i,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic [SEL_WIDTH-1:0]     cfg_f_sel_i,
    input  logic [NUM_COL_WIDTH-1:0] cfg_column_num_i,
    input  logic [NUM_COL_WIDTH-1:0] cfg_row_num_i,
    input  logic                     cfg_en_adder_1_i,
    input  logic                     cfg_en_adder_2_i,
    output logic                     ctl_rst_o,
    output logic                     ctl_load_o,
    output logic                     ctl_ready_o,
    output logic                     ctl_start_op_o,
    output logic [SEL_WIDTH-1:0]     f_sel_o,
    output logic [NUM_COL_WIDTH-1:0] column_num_o,
    output logic [NUM_COL_WIDTH-1:0] row_num_o,
    output logic                     en_adder_1_o,
    output logic                     en_adder_2_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [TILE_WIDTH-1:0]    tile_idx_o,
`ifdef FSEL_SEQ_PERF_EN
    output logic [31:0]              perf_run_cycles_o,
    output logic [31:0]              perf_stall_cycles_o,
`endif
    output logic [2:0]               state_o
);

    // Config stream: a word transfers on a cycle where cfg_valid_i && cfg_ready_o and
    // abort_i is low; cfg_ready_o is high only in FETCH and never depends on cfg_valid_i.

    sched_state_t          state_q, state_d;
    logic [TILE_WIDTH-1:0] num_tiles_q;
    logic [CNT_WIDTH-1:0]  op_cycles_q;
    logic [CNT_WIDTH-1:0]  op_eff;
    logic [CNT_WIDTH-1:0]  cnt_load_val;
    logic [PH_W-1:0]       phase;
    logic                  accept;
    logic                  cfg_fire;
    logic                  run_end;
    logic                  cnt_load;
    logic                  cnt_en;
    logic                  cnt_expire;

    assign accept   = (state_q == S_IDLE) && start_i;
    assign cfg_fire = (state_q == S_FETCH) && cfg_valid_i && !abort_i;
    assign run_end  = (state_q == S_RUN) && cnt_expire && !abort_i;
    assign op_eff   = (op_cycles_q == '0) ? CNT_WIDTH'(1) : op_cycles_q;

    assign cnt_load     = cfg_fire || (state_q == S_ARM);
    assign cnt_load_val = (state_q == S_ARM) ? op_eff : CNT_WIDTH'(LOAD_CYCLES);
    assign cnt_en       = (state_q == S_LOAD) || (state_q == S_RUN);

    sched_phase_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_phase_cnt (
        .clk_i    (clk_i),
        .f_sel_rst(f_sel_rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .expire   (cnt_expire)
    );

    always_ff @(posedge clk_i or posedge f_sel_rst) begin
        if (f_sel_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (num_tiles_i == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort_i)          state_d = S_IDLE;
                else if (cfg_valid_i) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (abort_i)         state_d = S_IDLE;
                else if (cnt_expire) state_d = S_ARM;
            end
            S_ARM: begin
                state_d = abort_i ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (cnt_expire) begin
                    // Last tile when the post-increment index reaches the job size.
                    state_d = ((tile_idx_o + TILE_WIDTH'(1)) == num_tiles_q) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign phase          = phase_of(state_q);
    assign ctl_load_o     = phase[PH_LOAD];
    assign ctl_ready_o    = phase[PH_READY];
    assign ctl_start_op_o = phase[PH_START];
    assign ctl_rst_o      = (state_q == S_IDLE) || (state_q == S_FETCH) || (state_q == S_DONE);
    assign cfg_ready_o    = (state_q == S_FETCH);
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign state_o        = state_q;

    always_ff @(posedge clk_i or posedge f_sel_rst) begin
        if (f_sel_rst) begin
            num_tiles_q <= '0;
            op_cycles_q <= '0;
            tile_idx_o  <= '0;
        end else if (accept) begin
            num_tiles_q <= num_tiles_i;
            op_cycles_q <= op_cycles_i;
            tile_idx_o  <= '0;
        end else if (run_end) begin
            tile_idx_o  <= tile_idx_o + TILE_WIDTH'(1);
        end
    end

    // Config outputs move only on a handshake, so they hold through LOAD, ARM and RUN.
    always_ff @(posedge clk_i or posedge f_sel_rst) begin
        if (f_sel_rst) begin
            f_sel_o      <= '0;
            column_num_o <= '0;
            row_num_o    <= '0;
            en_adder_1_o <= 1'b0;
            en_adder_2_o <= 1'b0;
        end else if (cfg_fire) begin
            f_sel_o      <= cfg_f_sel_i;
            column_num_o <= cfg_column_num_i;
            row_num_o    <= cfg_row_num_i;
            en_adder_1_o <= cfg_en_adder_1_i;
            en_adder_2_o <= cfg_en_adder_2_i;
        end
    end

`ifdef FSEL_SEQ_PERF_EN
    always_ff @(posedge clk_i or posedge f_sel_rst) begin
        if (f_sel_rst) begin
            perf_run_cycles_o   <= '0;
            perf_stall_cycles_o <= '0;
        end else if (accept) begin
            perf_run_cycles_o   <= '0;
            perf_stall_cycles_o <= '0;
        end else begin
            if ((state_q == S_RUN) && (perf_run_cycles_o != '1)) begin
                perf_run_cycles_o <= perf_run_cycles_o + 32'd1;
            end
            if ((state_q == S_FETCH) && !cfg_valid_i && (perf_stall_cycles_o != '1)) begin
                perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
            end
        end
    end
`endif

endmodule
